// File: rtl/posit_add_pkg.sv
// Shared constants and result type for the 16-bit posit adder datapath.
package posit_add_pkg;
  localparam int POSIT_N  = 16;
  localparam int POSIT_ES = 1;
  localparam logic [POSIT_N-1:0] POSIT_NAR = 16'h8000;

  typedef struct packed {
    logic [POSIT_N-1:0] data;
    logic               inf;
    logic               zero;
  } posit_res_t;
endpackage

// File: rtl/posit_res_fifo.sv
// First-word-fall-through result FIFO; a full FIFO still accepts a push when the head pops in the same cycle.
module posit_res_fifo #(
  parameter  int W     = 18,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_req,
  input  logic [W-1:0]   din,
  input  logic           pop_req,
  output logic [W-1:0]   dout,
  output logic           not_empty,
  output logic [PTR_W:0] count,
  output logic           drop
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign not_empty = (count != '0);
  assign pop       = pop_req && not_empty;
  assign push      = push_req && ((count != FULL) || pop);
  assign drop      = push_req && !push;
  assign dout      = mem[rd_ptr];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/posit_add_result_buf.sv
// Buffers posit adder results for a valid/ready consumer and meters issue credits so no result is lost.
module posit_add_result_buf
  import posit_add_pkg::*;
#(
  parameter  int N     = POSIT_N,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           issue,
  output logic           issue_ok,
  input  logic           res_valid,
  input  logic [N-1:0]   res_data,
  input  logic           res_inf,
  input  logic           res_zero,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic           out_inf,
  output logic           out_zero,
  output logic [PTR_W:0] count,
  output logic           err_ovf,
  output logic           err_credit
);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0] credits_used;
  logic [N+1:0]   head;
  logic           pop;
  logic           drop;

  assign pop      = out_valid && out_ready;
  assign issue_ok = (credits_used < FULL);
  assign {out_data, out_inf, out_zero} = head;

  posit_res_fifo #(
    .W     (N + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_req  (res_valid),
    .din       ({res_data, res_inf, res_zero}),
    .pop_req   (out_ready),
    .dout      (head),
    .not_empty (out_valid),
    .count     (count),
    .drop      (drop)
  );

  // Credits cover in-flight results plus FIFO occupancy; saturate at both ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_used <= '0;
      err_ovf      <= 1'b0;
      err_credit   <= 1'b0;
    end else begin
      if (drop) err_ovf <= 1'b1;
      if (issue && !issue_ok) err_credit <= 1'b1;
      case ({issue, pop})
        2'b10:   credits_used <= (credits_used == FULL) ? credits_used : credits_used + 1'b1;
        2'b01:   credits_used <= (credits_used == '0) ? credits_used : credits_used - 1'b1;
        default: credits_used <= credits_used;
      endcase
    end
  end
endmodule

// File: tb/tb_posit_add_result_buf.sv
// Randomized scoreboard bench for posit_add_result_buf against a queue-based reference model.
module tb_posit_add_result_buf;
  import posit_add_pkg::*;

  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             issue = 1'b0;
  logic             issue_ok;
  logic             res_valid = 1'b0;
  logic [15:0]      res_data = '0;
  logic             res_inf = 1'b0;
  logic             res_zero = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_data;
  logic             out_inf;
  logic             out_zero;
  logic [PTR_W:0]   count;
  logic             err_ovf;
  logic             err_credit;

  posit_add_result_buf #(.N(POSIT_N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .issue_ok   (issue_ok),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_inf    (res_inf),
    .res_zero   (res_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_inf    (out_inf),
    .out_zero   (out_zero),
    .count      (count),
    .err_ovf    (err_ovf),
    .err_credit (err_credit)
  );

  always #5 clk = ~clk;

  // Reference state: occupancy, credits and sticky errors after the most recent edge.
  posit_res_t exp_q[$];
  int occ = 0;
  int cred = 0;
  bit m_ovf = 1'b0;
  bit m_credit = 1'b0;
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_edge();
    bit pop_m;
    if (rst) begin
      occ = 0; cred = 0; m_ovf = 1'b0; m_credit = 1'b0;
      exp_q.delete();
    end else begin
      pop_m = (occ > 0) && out_ready;
      if (res_valid) begin
        if (occ < DEPTH || pop_m) begin
          exp_q.push_back('{data: res_data, inf: res_inf, zero: res_zero});
          occ++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (pop_m) occ--;
      if (issue && cred >= DEPTH) m_credit = 1'b1;
      if (issue && !pop_m) cred = (cred >= DEPTH) ? DEPTH : cred + 1;
      if (pop_m && !issue) cred = (cred == 0) ? 0 : cred - 1;
    end
  endtask

  task automatic step(input bit iss, input bit rv, input logic [15:0] d,
                      input bit fi, input bit fz, input bit rdy, input bit r);
    issue = iss; res_valid = rv; res_data = d; res_inf = fi; res_zero = fz;
    out_ready = rdy; rst = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: compare state every cycle, and the head against the scoreboard on each pop.
  always @(negedge clk) begin
    posit_res_t e;
    check("count", int'(count), occ);
    check("out_valid", int'(out_valid), int'(occ != 0));
    check("issue_ok", int'(issue_ok), int'(cred < DEPTH));
    check("err_ovf", int'(err_ovf), int'(m_ovf));
    check("err_credit", int'(err_credit), int'(m_credit));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", int'(out_data), int'(e.data));
        check("out_inf", int'(out_inf), int'(e.inf));
        check("out_zero", int'(out_zero), int'(e.zero));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    bit fi, fz, rv, rdy, iss;
    int k;

    step(0, 0, '0, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 0, 1);

    // Single result: 1.0 + 1.0 = 2.0 emerges three cycles after issue.
    step(1, 0, '0, 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 0);
    step(0, 1, 16'h5000, 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 1, 0);
    step(0, 0, '0, 0, 0, 0, 0);

    // Credit exhaustion, then an illegal ninth issue.
    for (int i = 0; i < 9; i++) step(1, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 16'h1000 + 16'(i), 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 0);
    // Full FIFO: simultaneous push and pop, then an overflow push.
    step(0, 1, 16'h2000, 0, 0, 1, 0);
    step(0, 1, 16'h7FFF, 0, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, '0, 0, 0, 1, 0);

    // Flags through pointer wrap with random back-pressure.
    step(0, 0, '0, 0, 0, 0, 1);
    k = 0;
    for (int i = 0; i < 60 && k < 20; i++) begin
      rdy = 1'($urandom_range(0, 1));
      rv  = (occ < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
      fi = 0; fz = 0; d = 16'($urandom);
      if (k % 3 == 0) begin fi = 1; d = POSIT_NAR; end
      else if (k % 3 == 1) begin fz = 1; d = 16'h0000; end
      step(0, rv, d, fi, fz, rdy, 0);
      if (rv) k++;
    end
    check("wrap_pushes", k, 20);
    step(0, 1, 16'h3333, 0, 0, 0, 1);
    step(0, 0, '0, 0, 0, 0, 0);

    // Random traffic including occasional credit violations and overflows.
    for (int i = 0; i < 300; i++) begin
      iss = (cred < DEPTH) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      rv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      step(iss, rv, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           rdy, ($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < DEPTH + 4; i++) step(0, 0, '0, 0, 0, 1, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/posit_add_result_buf.md
Name: posit_add_result_buf

Overview:
- Downstream stage of the 16-bit posit adder.
- Captures every adder result (r, inf, zero) on output_valid into a FIFO and presents it on a valid/ready interface to the consumer.
- The adder pipeline cannot stall, so the block also tracks credits. It tells the issuing logic when a new input_valid may be launched without losing a result.

Parameters:
- N, 16, posit width; must match the adder instance.
- DEPTH, 8, result FIFO entries and total credits; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- issue  input  1  high in the cycle the issuer drives adder input_valid.
- issue_ok  output  1  a new issue this cycle is guaranteed a FIFO slot.
- res_valid  input  1  adder output_valid.
- res_data  input  N  adder r.
- res_inf  input  1  adder inf.
- res_zero  input  1  adder zero.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head.
- out_data  output  N  head posit.
- out_inf  output  1  head inf flag.
- out_zero  output  1  head zero flag.
- count  output  PTR_W+1  FIFO occupancy.
- err_ovf  output  1  sticky: a result arrived with the FIFO full and was dropped.
- err_credit  output  1  sticky: issue asserted while issue_ok low.

Behaviour:
- Reset, synchronous, on rst high at an edge:
  - pointers = 0, count = 0, credits_used = 0, err_ovf = 0, err_credit = 0.
  - Hence out_valid = 0 and issue_ok = 1.
  - FIFO storage is not reset.
  - Reset mid-operation discards all stored and in-flight results.
  - Results that the adder emits after reset still push as normal. The issuer and adder must be flushed together by the system.
- Push:
  - Occurs when res_valid && (count < DEPTH || pop).
  - Writes {res_data, res_inf, res_zero} to mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
  - If res_valid and count == DEPTH and no pop: the entry is dropped, state is unchanged, err_ovf is set.
- Pop:
  - pop = out_valid && out_ready; rd_ptr wraps modulo DEPTH.
  - Head is first-word-fall-through: out_* = mem[rd_ptr] and out_valid = (count != 0).
  - Outputs are stable while out_valid && !out_ready.
- Latency: a result pushed at edge k appears on out_* after edge k (1 cycle). There is no empty bypass.
- Simultaneous push and pop:
  - count is unchanged.
  - Allowed when full: the write slot equals the old head, which is read before the edge.
- Credits:
  - credits_used = in-flight results + FIFO occupancy.
  - On issue: increment. On pop: decrement. Both together: unchanged.
  - res_valid does not touch credits.
  - issue_ok = (credits_used < DEPTH), combinational from the register.
  - issue while !issue_ok: err_credit is set and credits_used saturates at DEPTH.
  - pop with credits_used == 0 cannot occur legally; the counter saturates at 0.
- Arithmetic: all counters are PTR_W+1 bits; pointers are PTR_W bits with natural wrap.
- Flags pass through unmodified. The block does not reinterpret NaR or zero encodings.

Decomposition:
- Package posit_add_pkg holds:
  - constants POSIT_N=16 and POSIT_ES=1.
  - typedef posit_res_t packed struct {logic [POSIT_N-1:0] data; logic inf; logic zero;}.
  - the NaR constant 16'h8000.
- One sub-module is natural: posit_res_fifo (storage, pointers, count, FWFT head).
- Credit counter and error flags live in the top.

Test Plan:
- Reset check: assert rst for 2 cycles -> out_valid=0, issue_ok=1, count=0, err_ovf=0, err_credit=0.
- Single result: issue 1 cycle; 3 cycles later res_valid with res_data=16'h5000 (1.0+1.0=2.0) -> next cycle out_valid=1 and out_data=16'h5000. Pop with out_ready=1 -> count=0 and credits back to 0.
- Credit exhaustion: 8 back-to-back issues with out_ready=0 -> issue_ok falls after the 8th. A 9th issue sets err_credit=1. Then 8 results push in order, count=8, err_ovf=0.
- Full with simultaneous push/pop: FIFO full (entries 16'h1000..16'h1007), out_ready=1 and res_valid with 16'h2000 in the same cycle -> count stays 8. Head sequence continues 16'h1001..16'h1007, then 16'h2000.
- Overflow: FIFO full, out_ready=0, res_valid with 16'h7FFF -> value not stored, err_ovf=1 sticky until rst.
- Flags and wrap: push res_inf=1/data=16'h8000, then res_zero=1/data=16'h0000, across 20 entries with random out_ready -> order, data and flags preserved through pointer wrap. Mid-stream rst clears count to 0 in 1 cycle.
